// File: rtl/vga_reg_bank_sync_if.sv
// Bus bundle between the RTC controller / VGA renderer side and the
// double-buffered display register bank.
interface vga_reg_bank_sync_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 9,
    parameter int ADDR_W   = 4
);
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       wr_ready;
    logic                       wr_drop;
    logic                       commit_req;
    logic                       frame_sync;
    logic                       commit_done;
    logic                       forced;
    logic [ADDR_W-1:0]          rd_addr;
    logic [DATA_W-1:0]          rd_data;
    logic [NUM_REGS*DATA_W-1:0] disp_flat;

    modport master (
        output wr_en, wr_addr, wr_data, commit_req, frame_sync, rd_addr,
        input  wr_ready, wr_drop, commit_done, forced, rd_data, disp_flat
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit_req, frame_sync, rd_addr,
        output wr_ready, wr_drop, commit_done, forced, rd_data, disp_flat
    );
endinterface

// File: rtl/vga_reg_bank_sync.sv
// Double-buffered register bank: the RTC controller fills a staging bank,
// and the display bank seen by the VGA renderer is swapped in atomically at
// a frame boundary (or after a timeout) so a frame never shows a torn time.
module vga_reg_bank_sync #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 9,
    parameter int ADDR_W   = 4,
    parameter int TO_W     = 20,
    parameter int TIMEOUT  = 833334
) (
    input logic                clk,
    input logic                reset,
    vga_reg_bank_sync_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, COPY} state_t;

    // Last ARMED cycle index: leaving after exactly TIMEOUT cycles in ARMED.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [TO_W-1:0]   to_count;
    logic              timeout_hit;
    logic              ready;
    logic              wr_accept;
    logic              copy_forced;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] staging [NUM_REGS];
    logic [DATA_W-1:0] display [NUM_REGS];

    assign wr_idx      = bus.wr_addr;
    assign rd_idx      = bus.rd_addr;
    assign timeout_hit = (TIMEOUT != 0) && (to_count == TO_LAST);
    assign wr_accept   = bus.wr_en && ready && (int'(wr_idx) < NUM_REGS);
    assign bus.wr_ready = ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: arm on request, copy on frame sync (which beats the timeout), copy lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.commit_req) next_state = ARMED;
            ARMED:   if (bus.frame_sync || timeout_hit) next_state = COPY;
            COPY:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state: staging only accepts writes while idle.
    always_comb begin
        ready = (state == IDLE);
    end

    // Timeout counter runs only while staying in ARMED; zero on entry and exit.
    always_ff @(posedge clk) begin
        if (reset || state != ARMED || next_state != ARMED) to_count <= '0;
        else                                                to_count <= to_count + 1'b1;
    end

    // Remember why ARMED was left so the copy can report it.
    always_ff @(posedge clk) begin
        if (reset)                                         copy_forced <= 1'b0;
        else if (state == ARMED && next_state == COPY)     copy_forced <= !bus.frame_sync;
    end

    // Staging bank: written by the controller while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) staging[i] <= '0;
        end else if (wr_accept) begin
            staging[wr_idx] <= bus.wr_data;
        end
    end

    // Display bank: whole-bank transfer from staging in the COPY cycle only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) display[i] <= '0;
        end else if (state == COPY) begin
            for (int i = 0; i < NUM_REGS; i++) display[i] <= staging[i];
        end
    end

    // Status pulses and the sticky forced flag, all aligned with the display update.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wr_drop     <= 1'b0;
            bus.commit_done <= 1'b0;
            bus.forced      <= 1'b0;
        end else begin
            bus.wr_drop     <= bus.wr_en && !wr_accept;
            bus.commit_done <= (state == COPY);
            if (state == COPY) bus.forced <= copy_forced;
        end
    end

    // Registered read port; out-of-range indices read as zero.
    always_ff @(posedge clk) begin
        if (reset)                          bus.rd_data <= '0;
        else if (int'(rd_idx) < NUM_REGS)   bus.rd_data <= display[rd_idx];
        else                                bus.rd_data <= '0;
    end

    // Flattened view of the display bank, index 0 in the LSBs.
    always_comb begin
        bus.disp_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) bus.disp_flat[i*DATA_W +: DATA_W] = display[i];
    end
endmodule

// File: tb/tb_vga_reg_bank_sync.sv
// Testbench for vga_reg_bank_sync: directed vector table, hand-written
// timeout/reset sequences, and randomized traffic against a reference model.
module tb_vga_reg_bank_sync;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 9;
    localparam int ADDR_W   = 4;
    localparam int TO_W     = 20;
    localparam int TIMEOUT  = 16;
    localparam int FLAT_W   = NUM_REGS * DATA_W;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    vga_reg_bank_sync_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) bus ();

    vga_reg_bank_sync #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .TO_W(TO_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Reference model state: the banks as plain arrays plus a commit phase.
    int stg [NUM_REGS];
    int dsp [NUM_REGS];
    bit m_armed;
    bit m_copying;
    bit m_copy_forced;
    int m_age;
    bit exp_drop;
    bit exp_done;
    bit exp_forced;
    int exp_rd;

    // Transaction view of one clock: accept/refuse the write, advance the commit.
    always @(posedge clk) begin
        bit idle;
        idle = !m_armed && !m_copying;
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin stg[i] = 0; dsp[i] = 0; end
            m_armed = 0; m_copying = 0; m_copy_forced = 0; m_age = 0;
            exp_drop = 0; exp_done = 0; exp_forced = 0; exp_rd = 0;
        end else begin
            exp_rd   = (int'(bus.rd_addr) < NUM_REGS) ? dsp[bus.rd_addr] : 0;
            exp_done = 0;
            exp_drop = bus.wr_en && !(idle && int'(bus.wr_addr) < NUM_REGS);
            if (bus.wr_en && !exp_drop) stg[bus.wr_addr] = int'(bus.wr_data);
            if (m_copying) begin
                dsp        = stg;
                exp_done   = 1;
                exp_forced = m_copy_forced;
                m_copying  = 0;
            end else if (m_armed) begin
                m_age++;
                if (bus.frame_sync) begin
                    m_armed = 0; m_copying = 1; m_copy_forced = 0;
                end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
                    m_armed = 0; m_copying = 1; m_copy_forced = 1;
                end
            end else if (bus.commit_req) begin
                m_armed = 1;
                m_age   = 0;
            end
        end
    end

    function automatic logic [FLAT_W-1:0] modelFlat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = DATA_W'(dsp[i]);
        return f;
    endfunction

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       cr;
        logic       fs;
        logic [3:0] ra;
        logic       ready;
        logic       drop;
        logic       done;
        logic       frc;
        logic [7:0] rd;
        logic [23:0] flat;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [7:0] wd, logic cr, logic fs,
                                logic [3:0] ra, logic ready, logic drop, logic done, logic frc,
                                logic [7:0] rd, logic [23:0] flat);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.cr = cr; v.fs = fs; v.ra = ra;
        v.ready = ready; v.drop = drop; v.done = done; v.frc = frc; v.rd = rd; v.flat = flat;
        return v;
    endfunction

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                 input logic cr, input logic fs, input logic [3:0] ra,
                                 input logic rst);
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.commit_req = cr;
        bus.frame_sync = fs;
        bus.rd_addr    = ra;
        reset          = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [FLAT_W-1:0] actual,
                               input logic [FLAT_W-1:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".wr_ready"},    FLAT_W'(bus.wr_ready),    FLAT_W'(!m_armed && !m_copying));
        checkOutput({tag, ".wr_drop"},     FLAT_W'(bus.wr_drop),     FLAT_W'(exp_drop));
        checkOutput({tag, ".commit_done"}, FLAT_W'(bus.commit_done), FLAT_W'(exp_done));
        checkOutput({tag, ".forced"},      FLAT_W'(bus.forced),      FLAT_W'(exp_forced));
        checkOutput({tag, ".rd_data"},     FLAT_W'(bus.rd_data),     FLAT_W'(exp_rd));
        checkOutput({tag, ".disp_flat"},   bus.disp_flat,            modelFlat());
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int lat;
        int pulses;

        reset          = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.commit_req = 1'b0;
        bus.frame_sync = 1'b0;
        bus.rd_addr    = '0;

        // Reset state.
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("reset.wr_ready",    FLAT_W'(bus.wr_ready),    FLAT_W'(1));
        checkOutput("reset.wr_drop",     FLAT_W'(bus.wr_drop),     FLAT_W'(0));
        checkOutput("reset.commit_done", FLAT_W'(bus.commit_done), FLAT_W'(0));
        checkOutput("reset.forced",      FLAT_W'(bus.forced),      FLAT_W'(0));
        checkOutput("reset.rd_data",     FLAT_W'(bus.rd_data),     FLAT_W'(0));
        checkOutput("reset.disp_flat",   bus.disp_flat,            FLAT_W'(0));

        // Directed vectors: writes, refused writes, sync commit, read latency, ignored syncs.
        vecs[0]  = mk(1, 4'd0, 8'h59, 0, 0, 4'd0,  1, 0, 0, 0, 8'h00, 24'h000000);
        vecs[1]  = mk(1, 4'd2, 8'h12, 0, 0, 4'd0,  1, 0, 0, 0, 8'h00, 24'h000000);
        vecs[2]  = mk(1, 4'd9, 8'hAA, 0, 0, 4'd0,  1, 1, 0, 0, 8'h00, 24'h000000);
        vecs[3]  = mk(0, 4'd0, 8'h00, 1, 0, 4'd12, 0, 0, 0, 0, 8'h00, 24'h000000);
        vecs[4]  = mk(1, 4'd1, 8'h33, 0, 0, 4'd0,  0, 1, 0, 0, 8'h00, 24'h000000);
        for (int i = 5; i <= 12; i++)
            vecs[i] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0, 8'h00, 24'h000000);
        vecs[13] = mk(0, 4'd0, 8'h00, 0, 1, 4'd0,  0, 0, 0, 0, 8'h00, 24'h000000);
        vecs[14] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  1, 0, 1, 0, 8'h00, 24'h120059);
        vecs[15] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  1, 0, 0, 0, 8'h59, 24'h120059);
        vecs[16] = mk(0, 4'd0, 8'h00, 0, 0, 4'd1,  1, 0, 0, 0, 8'h00, 24'h120059);
        vecs[17] = mk(0, 4'd0, 8'h00, 0, 0, 4'd2,  1, 0, 0, 0, 8'h12, 24'h120059);
        vecs[18] = mk(0, 4'd0, 8'h00, 0, 0, 4'd9,  1, 0, 0, 0, 8'h00, 24'h120059);
        vecs[19] = mk(0, 4'd0, 8'h00, 0, 1, 4'd0,  1, 0, 0, 0, 8'h59, 24'h120059);
        vecs[20] = mk(0, 4'd0, 8'h00, 1, 1, 4'd0,  0, 0, 0, 0, 8'h59, 24'h120059);
        vecs[21] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  0, 0, 0, 0, 8'h59, 24'h120059);
        vecs[22] = mk(0, 4'd0, 8'h00, 0, 1, 4'd0,  0, 0, 0, 0, 8'h59, 24'h120059);
        vecs[23] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  1, 0, 1, 0, 8'h59, 24'h120059);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cr, vecs[i].fs, vecs[i].ra, 1'b0);
            checkOutput($sformatf("vec%0d.wr_ready", i),    FLAT_W'(bus.wr_ready),    FLAT_W'(vecs[i].ready));
            checkOutput($sformatf("vec%0d.wr_drop", i),     FLAT_W'(bus.wr_drop),     FLAT_W'(vecs[i].drop));
            checkOutput($sformatf("vec%0d.commit_done", i), FLAT_W'(bus.commit_done), FLAT_W'(vecs[i].done));
            checkOutput($sformatf("vec%0d.forced", i),      FLAT_W'(bus.forced),      FLAT_W'(vecs[i].frc));
            checkOutput($sformatf("vec%0d.rd_data", i),     FLAT_W'(bus.rd_data),     FLAT_W'(vecs[i].rd));
            checkOutput($sformatf("vec%0d.disp_flat", i),   bus.disp_flat,            FLAT_W'(vecs[i].flat));
        end

        // Timeout commit: 16 cycles in ARMED, then COPY, then commit_done with forced set.
        applyStimulus(1'b1, 4'd3, 8'h07, 1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            idleCycle();
            if (bus.commit_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput("timeout.latency",   FLAT_W'(lat),         FLAT_W'(TIMEOUT + 1));
        checkOutput("timeout.forced",    FLAT_W'(bus.forced),  FLAT_W'(1));
        checkOutput("timeout.disp_flat", bus.disp_flat,        FLAT_W'(32'h07120059));
        idleCycle();
        checkOutput("timeout.single_pulse", FLAT_W'(bus.commit_done), FLAT_W'(0));
        checkOutput("timeout.forced_sticky", FLAT_W'(bus.forced),     FLAT_W'(1));

        // Reset while ARMED: commit discarded, everything zeroed, later frame_sync does nothing.
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("armrst.wr_ready",    FLAT_W'(bus.wr_ready),    FLAT_W'(1));
        checkOutput("armrst.commit_done", FLAT_W'(bus.commit_done), FLAT_W'(0));
        checkOutput("armrst.forced",      FLAT_W'(bus.forced),      FLAT_W'(0));
        checkOutput("armrst.rd_data",     FLAT_W'(bus.rd_data),     FLAT_W'(0));
        checkOutput("armrst.disp_flat",   bus.disp_flat,            FLAT_W'(0));
        pulses = 0;
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
        if (bus.commit_done === 1'b1) pulses++;
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            if (bus.commit_done === 1'b1) pulses++;
        end
        checkOutput("armrst.no_done",   FLAT_W'(pulses), FLAT_W'(0));
        checkOutput("armrst.disp_idle", bus.disp_flat,   FLAT_W'(0));

        // Sync commit after a forced one clears forced; staging was zeroed by the reset.
        applyStimulus(1'b1, 4'd5, 8'h44, 1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        idleCycle();
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
        checkOutput("sync.copy_no_done", FLAT_W'(bus.commit_done), FLAT_W'(0));
        idleCycle();
        checkOutput("sync.commit_done", FLAT_W'(bus.commit_done), FLAT_W'(1));
        checkOutput("sync.forced",      FLAT_W'(bus.forced),      FLAT_W'(0));
        checkOutput("sync.disp_flat",   bus.disp_flat,            FLAT_W'(48'h440000000000));

        // Randomized traffic against the reference model.
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)),
                          8'($urandom),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 11) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 149) == 0));
            checkModel($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
